bnn_seq: RTL and testbench
==========================

// Module: bnn_seq
// PURPOSE
//  Bus initiator that drives the BNN accelerator's command port to evaluate one neuron layer
//  slice without CPU involvement. On start: issues ini, row-wise acc, pool, norm and norm8
//  commands, then one activation read. Captures the 32 activation bits (one per core).
//  Sits beside the core on the data-port side of the BNN memory, muxed in by an external arbiter.
// PARAMETERS
//  ROW_W   10  width of row index (param RAM rows, p_addr[11:2])
//  POOL_W  4   width of pooling-window count
//  DRAIN   1   idle cycles between last granted command and the activation read (>=1)
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset; asynchronous, active-high
//  start       in   1      1-cycle pulse; sampled only in IDLE
//  row_base    in   ROW_W  first acc row
//  n_rows      in   ROW_W  acc rows per pooling window
//  n_pool      in   POOL_W number of pooling windows
//  norm_row    in   ROW_W  row of norm params; norm8 uses norm_row+1
//  norm8_en    in   1      issue norm8 after norm
//  ini_val     in   16     value loaded into acc by ini/pool (p_wdata[15:0])
//  busy        out  1      high from cycle after accepted start until done
//  done        out  1      1-cycle pulse, activ valid same cycle
//  activ       out  32     captured activation bits, bit g = core g
//  b_req       out  1      BNN command request
//  p_we        out  1      always 0
//  p_be        out  4      byte enables / command qualifier
//  p_addr      out  32     command address
//  p_wdata     out  32     command data
//  p_gnt       in   1      grant; command consumed on cycle with b_req&p_gnt
//  p_rdata     in   32     read data; activation bits valid the cycle after a granted command
// BEHAVIOUR
//  Reset: b_req=0 p_we=0 p_be=0 p_addr=0 p_wdata=0 busy=0 done=0 activ=0, FSM=IDLE.
//  All bus outputs registered; while b_req&~p_gnt all bus outputs and counters hold.
//  Command encoding (p_addr upper bits 0):
//   ACC   addr={bit12=0,row,2'b00} be=4'hF wdata=0
//   NORM  addr={bit12=0,norm_row,2'b00} be=4'b1011;  NORM8 same, row norm_row+1, be=4'b1001
//   INI   addr=32'h1000 be=4'hF wdata={16'h0,ini_val};  POOL addr=32'h1004, same data
//   READ  addr=32'h100C be=4'hF wdata=0 (no-op command; returns activations)
//  FSM: IDLE -> INI -> ACC(x n_rows) -> [POOL -> ACC(x n_rows)] x (n_pool-1) -> POOL -> NORM
//   -> NORM8 (if norm8_en) -> DRAIN (b_req=0 for DRAIN cycles) -> READ -> CAPT -> IDLE.
//  Each state advances on grant; ACC advances row pointer, decrements row count.
//  Row pointer starts at row_base, +1 per granted ACC, never reset between windows;
//   wraps modulo 2^ROW_W. norm_row+1 also wraps.
//  CAPT: activ<=p_rdata, done=1, busy falls next cycle; b_req=0 in CAPT.
//  start in IDLE latches all inputs; inputs ignored while busy; start while busy ignored.
//  n_rows==0 or n_pool==0: no bus traffic, done pulses cycle after start, activ unchanged.
//  Back-to-back: start in same cycle as done is ignored (FSM not yet IDLE).
//  Async reset mid-operation: outputs to reset values immediately; partial layer abandoned.
//  Integration rule: CPU p_req must be 0 while busy (arbiter guarantees).
// TESTING
//  1. Reset, start row_base=5 n_rows=3 n_pool=2 norm_row=40 norm8_en=1, p_gnt=1 -> granted seq
//     INI,ACC r5,r6,r7,POOL,ACC r8,r9,r10,POOL,NORM r40,NORM8 r41,idle,READ; done 15 cycles after start.
//  2. Same as 1 with p_gnt low 2 cycles during second ACC -> outputs frozen, sequence identical, done +2.
//  3. row_base=1022 n_rows=4 n_pool=1 -> ACC rows 1022,1023,0,1.
//  4. n_pool=0 -> b_req never asserted, done one cycle after start, activ unchanged.
//  5. rst pulsed during ACC -> b_req=0 same cycle, busy=0; new start runs full sequence from INI.
//  6. Bench model returns p_rdata=32'hA5A5_0F0F after READ -> activ=32'hA5A5_0F0F with done; norm8_en=0 skips NORM8.

Source files
------------

// File: rtl/bnn_seq.sv
// BNN layer sequencer: a bus initiator that walks the accelerator's command
// port through ini, row-wise acc, pool, norm/norm8 and a final activation
// read, then captures the 32 activation bits.
module bnn_seq #(
    parameter int ROW_W  = 10,
    parameter int POOL_W = 4,
    parameter int DRAIN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  row_base,
    input  logic [ROW_W-1:0]  n_rows,
    input  logic [POOL_W-1:0] n_pool,
    input  logic [ROW_W-1:0]  norm_row,
    input  logic              norm8_en,
    input  logic [15:0]       ini_val,
    output logic              busy,
    output logic              done,
    output logic [31:0]       activ,
    output logic              b_req,
    output logic              p_we,
    output logic [3:0]        p_be,
    output logic [31:0]       p_addr,
    output logic [31:0]       p_wdata,
    input  logic              p_gnt,
    input  logic [31:0]       p_rdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_INI, S_ACC, S_POOL, S_NORM, S_NORM8,
        S_DRAIN, S_READ, S_RWAIT, S_CAPT
    } state_t;

    state_t            state_r, state_s;
    logic [ROW_W-1:0]  row_ptr_r, row_ptr_s;
    logic [ROW_W-1:0]  row_cnt_r, row_cnt_s;
    logic [POOL_W-1:0] pool_cnt_r, pool_cnt_s;
    logic [7:0]        drain_cnt_r, drain_cnt_s;
    logic [ROW_W-1:0]  n_rows_r, n_rows_s;
    logic [ROW_W-1:0]  norm_row_r, norm_row_s;
    logic              norm8_en_r, norm8_en_s;
    logic [15:0]       ini_val_r, ini_val_s;
    logic [ROW_W-1:0]  norm8_row_s;
    logic              req_s;
    logic [3:0]        be_s;
    logic [31:0]       addr_s;
    logic [31:0]       wdata_s;

    // The accelerator's data port is only ever written through commands.
    assign p_we = 1'b0;

    // Next-state and counter update; every bus state waits for its grant.
    always_comb begin
        state_s     = state_r;
        row_ptr_s   = row_ptr_r;
        row_cnt_s   = row_cnt_r;
        pool_cnt_s  = pool_cnt_r;
        drain_cnt_s = drain_cnt_r;
        n_rows_s    = n_rows_r;
        norm_row_s  = norm_row_r;
        norm8_en_s  = norm8_en_r;
        ini_val_s   = ini_val_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    row_ptr_s  = row_base;
                    row_cnt_s  = n_rows;
                    pool_cnt_s = n_pool;
                    n_rows_s   = n_rows;
                    norm_row_s = norm_row;
                    norm8_en_s = norm8_en;
                    ini_val_s  = ini_val;
                    if ((n_rows == {ROW_W{1'b0}}) || (n_pool == {POOL_W{1'b0}})) begin
                        state_s = S_CAPT;
                    end else begin
                        state_s = S_INI;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_INI: begin
                if (p_gnt) state_s = S_ACC;
                else       state_s = S_INI;
            end
            S_ACC: begin
                if (p_gnt) begin
                    row_ptr_s = row_ptr_r + ROW_W'(1);
                    if (row_cnt_r == ROW_W'(1)) begin
                        state_s    = S_POOL;
                        row_cnt_s  = n_rows_r;
                        pool_cnt_s = pool_cnt_r - POOL_W'(1);
                    end else begin
                        row_cnt_s  = row_cnt_r - ROW_W'(1);
                    end
                end else begin
                    state_s = S_ACC;
                end
            end
            S_POOL: begin
                if (p_gnt) begin
                    if (pool_cnt_r == {POOL_W{1'b0}}) state_s = S_NORM;
                    else                               state_s = S_ACC;
                end else begin
                    state_s = S_POOL;
                end
            end
            S_NORM: begin
                if (p_gnt) begin
                    drain_cnt_s = 8'(DRAIN - 1);
                    if (norm8_en_r) state_s = S_NORM8;
                    else            state_s = S_DRAIN;
                end else begin
                    state_s = S_NORM;
                end
            end
            S_NORM8: begin
                if (p_gnt) begin
                    drain_cnt_s = 8'(DRAIN - 1);
                    state_s     = S_DRAIN;
                end else begin
                    state_s = S_NORM8;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_r == 8'd0) state_s = S_READ;
                else                     drain_cnt_s = drain_cnt_r - 8'd1;
            end
            S_READ: begin
                if (p_gnt) state_s = S_RWAIT;
                else       state_s = S_READ;
            end
            S_RWAIT: state_s = S_CAPT;
            S_CAPT:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    assign norm8_row_s = norm_row_s + ROW_W'(1);

    // Encode the command for the state being entered so the bus is registered.
    always_comb begin
        req_s   = 1'b0;
        be_s    = 4'h0;
        addr_s  = 32'h0;
        wdata_s = 32'h0;
        case (state_s)
            S_INI: begin
                req_s = 1'b1; be_s = 4'hF; addr_s = 32'h0000_1000;
                wdata_s = {16'h0000, ini_val_s};
            end
            S_ACC: begin
                req_s = 1'b1; be_s = 4'hF;
                addr_s = {{(30-ROW_W){1'b0}}, row_ptr_s, 2'b00};
            end
            S_POOL: begin
                req_s = 1'b1; be_s = 4'hF; addr_s = 32'h0000_1004;
                wdata_s = {16'h0000, ini_val_s};
            end
            S_NORM: begin
                req_s = 1'b1; be_s = 4'b1011;
                addr_s = {{(30-ROW_W){1'b0}}, norm_row_s, 2'b00};
            end
            S_NORM8: begin
                req_s = 1'b1; be_s = 4'b1001;
                addr_s = {{(30-ROW_W){1'b0}}, norm8_row_s, 2'b00};
            end
            S_READ: begin
                req_s = 1'b1; be_s = 4'hF; addr_s = 32'h0000_100C;
            end
            default: begin
                req_s = 1'b0;
            end
        endcase
    end

    // State, counters, latched operands and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            row_ptr_r   <= {ROW_W{1'b0}};
            row_cnt_r   <= {ROW_W{1'b0}};
            pool_cnt_r  <= {POOL_W{1'b0}};
            drain_cnt_r <= 8'd0;
            n_rows_r    <= {ROW_W{1'b0}};
            norm_row_r  <= {ROW_W{1'b0}};
            norm8_en_r  <= 1'b0;
            ini_val_r   <= 16'h0000;
            b_req       <= 1'b0;
            p_be        <= 4'h0;
            p_addr      <= 32'h0;
            p_wdata     <= 32'h0;
            busy        <= 1'b0;
            done        <= 1'b0;
            activ       <= 32'h0;
        end else begin
            state_r     <= state_s;
            row_ptr_r   <= row_ptr_s;
            row_cnt_r   <= row_cnt_s;
            pool_cnt_r  <= pool_cnt_s;
            drain_cnt_r <= drain_cnt_s;
            n_rows_r    <= n_rows_s;
            norm_row_r  <= norm_row_s;
            norm8_en_r  <= norm8_en_s;
            ini_val_r   <= ini_val_s;
            b_req       <= req_s;
            p_be        <= be_s;
            p_addr      <= addr_s;
            p_wdata     <= wdata_s;
            busy        <= (state_s != S_IDLE);
            done        <= (state_s == S_CAPT);
            if (state_r == S_RWAIT) activ <= p_rdata;
            else                    activ <= activ;
        end
    end

endmodule

// File: tb/tb_bnn_seq.sv
// Scoreboard bench for bnn_seq: stimulus pushes expected commands and done
// events; a negedge monitor pops and compares on every grant and done pulse.
module tb_bnn_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  row_base = 10'd0, n_rows = 10'd0, norm_row = 10'd0;
    logic [3:0]  n_pool = 4'd0;
    logic        norm8_en = 1'b0;
    logic [15:0] ini_val = 16'h0;
    logic        busy, done, b_req, p_we;
    logic [31:0] activ, p_addr, p_wdata;
    logic [3:0]  p_be;
    logic        p_gnt = 1'b1;
    logic [31:0] p_rdata = 32'hDEAD_BEEF;

    bnn_seq #(.ROW_W(10), .POOL_W(4), .DRAIN(1)) dut (
        .clk(clk), .rst(rst), .start(start), .row_base(row_base), .n_rows(n_rows),
        .n_pool(n_pool), .norm_row(norm_row), .norm8_en(norm8_en), .ini_val(ini_val),
        .busy(busy), .done(done), .activ(activ), .b_req(b_req), .p_we(p_we),
        .p_be(p_be), .p_addr(p_addr), .p_wdata(p_wdata), .p_gnt(p_gnt), .p_rdata(p_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } cmd_t;
    typedef struct { logic [31:0] activ; int lat; } dn_t;

    cmd_t cmd_q[$];
    dn_t  dn_q[$];
    int   compares = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    logic [31:0] rval = 32'h0;
    logic [31:0] last_activ = 32'h0;
    logic rd_pending = 1'b0;
    logic prev_stall = 1'b0;
    logic [68:0] prev_bus = 69'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bench model of the BNN memory read path: activations the cycle after READ.
    always @(posedge clk) begin
        #1;
        p_rdata = rd_pending ? rval : 32'hDEAD_BEEF;
    end

    // Monitor: check granted commands, done events and stall hold behaviour.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                compares++;
                if ({b_req, p_addr, p_be, p_wdata} !== prev_bus) begin
                    errors++;
                    $display("FAIL stall_hold got=%h want=%h", {b_req, p_addr, p_be, p_wdata}, prev_bus);
                end
            end
            prev_stall = b_req && !p_gnt;
            prev_bus   = {b_req, p_addr, p_be, p_wdata};
            if (b_req && p_gnt) begin
                compares++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cmd got addr=%h be=%h wdata=%h", p_addr, p_be, p_wdata);
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    if (p_addr !== e.addr || p_be !== e.be || p_wdata !== e.wdata || p_we !== 1'b0) begin
                        errors++;
                        $display("FAIL cmd got addr=%h be=%h wdata=%h we=%b want addr=%h be=%h wdata=%h we=0",
                                 p_addr, p_be, p_wdata, p_we, e.addr, e.be, e.wdata);
                    end
                end
            end
            rd_pending = b_req && p_gnt && (p_addr == 32'h0000_100C);
            if (done) begin
                compares++;
                if (dn_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got activ=%h", activ);
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    if (activ !== d.activ || (cyc - start_cyc) != d.lat) begin
                        errors++;
                        $display("FAIL done got activ=%h lat=%0d want activ=%h lat=%0d",
                                 activ, cyc - start_cyc, d.activ, d.lat);
                    end
                end
            end
        end else begin
            rd_pending = 1'b0;
            prev_stall = 1'b0;
        end
    end

    task automatic push_cmd(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        cmd_t c;
        c.addr = a; c.be = be; c.wdata = wd;
        cmd_q.push_back(c);
    endtask

    task automatic push_done(input logic [31:0] av, input int lat);
        dn_t d;
        d.activ = av; d.lat = lat;
        dn_q.push_back(d);
        last_activ = av;
    endtask

    // Expected command stream for one layer slice (empty for degenerate sizes).
    task automatic push_layer(input logic [9:0] rb, input logic [9:0] nr, input logic [3:0] np,
                              input logic [9:0] nrow, input logic n8, input logic [15:0] iv,
                              input logic [31:0] rv, input int lat);
        logic [9:0] r;
        logic [9:0] r8;
        if (nr == 10'd0 || np == 4'd0) begin
            push_done(last_activ, 1);
        end else begin
            r = rb;
            push_cmd(32'h1000, 4'hF, {16'h0, iv});
            for (int w = 0; w < int'(np); w++) begin
                for (int k = 0; k < int'(nr); k++) begin
                    push_cmd({20'h0, r, 2'b00}, 4'hF, 32'h0);
                    r = r + 10'd1;
                end
                push_cmd(32'h1004, 4'hF, {16'h0, iv});
            end
            push_cmd({20'h0, nrow, 2'b00}, 4'b1011, 32'h0);
            r8 = nrow + 10'd1;
            if (n8) push_cmd({20'h0, r8, 2'b00}, 4'b1001, 32'h0);
            push_cmd(32'h100C, 4'hF, 32'h0);
            rval = rv;
            push_done(rv, lat);
        end
    endtask

    task automatic kick(input logic [9:0] rb, input logic [9:0] nr, input logic [3:0] np,
                        input logic [9:0] nrow, input logic n8, input logic [15:0] iv);
        @(posedge clk); #1;
        row_base = rb; n_rows = nr; n_pool = np; norm_row = nrow; norm8_en = n8; ini_val = iv;
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        row_base = 10'h3FF; n_rows = 10'h3FF; n_pool = 4'hF; norm_row = 10'h155; ini_val = 16'hFFFF;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200 && dn_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        compares++;
        if (dn_q.size() != 0 || cmd_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_end got pending_done=%0d pending_cmds=%0d busy=%b want 0 0 0",
                     name, dn_q.size(), cmd_q.size(), busy);
            dn_q.delete(); cmd_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        compares++;
        if ({b_req, p_we, p_be, p_addr, p_wdata, busy, done, activ} !== 103'h0) begin
            errors++;
            $display("FAIL reset_state got b_req=%b be=%h addr=%h busy=%b done=%b activ=%h",
                     b_req, p_be, p_addr, busy, done, activ);
        end
        rst = 1'b0;

        // 1: two windows of three rows, norm8 on, continuous grant.
        push_cmd(32'h1000, 4'hF, 32'h0000_00AB);
        push_cmd(32'h0014, 4'hF, 32'h0); push_cmd(32'h0018, 4'hF, 32'h0); push_cmd(32'h001C, 4'hF, 32'h0);
        push_cmd(32'h1004, 4'hF, 32'h0000_00AB);
        push_cmd(32'h0020, 4'hF, 32'h0); push_cmd(32'h0024, 4'hF, 32'h0); push_cmd(32'h0028, 4'hF, 32'h0);
        push_cmd(32'h1004, 4'hF, 32'h0000_00AB);
        push_cmd(32'h00A0, 4'b1011, 32'h0); push_cmd(32'h00A4, 4'b1001, 32'h0);
        push_cmd(32'h100C, 4'hF, 32'h0);
        rval = 32'hC3C3_3C3C;
        push_done(32'hC3C3_3C3C, 15);
        kick(10'd5, 10'd3, 4'd2, 10'd40, 1'b1, 16'h00AB);
        wait_done("t1");

        // 2: same layer, grant withheld for two cycles during the second ACC.
        push_layer(10'd5, 10'd3, 4'd2, 10'd40, 1'b1, 16'h00AB, 32'h1234_5678, 17);
        fork
            kick(10'd5, 10'd3, 4'd2, 10'd40, 1'b1, 16'h00AB);
            begin
                repeat (4) @(posedge clk); #1 p_gnt = 1'b0;
                repeat (2) @(posedge clk); #1 p_gnt = 1'b1;
            end
        join
        wait_done("t2");

        // 3: row pointer and norm8 row wrap at 2^10.
        push_layer(10'd1022, 10'd4, 4'd1, 10'd1023, 1'b1, 16'h5A5A, 32'h0F0F_F0F0, 12);
        kick(10'd1022, 10'd4, 4'd1, 10'd1023, 1'b1, 16'h5A5A);
        wait_done("t3");

        // 4: degenerate sizes produce no bus traffic and keep activ.
        push_layer(10'd7, 10'd2, 4'd0, 10'd3, 1'b1, 16'h1111, 32'h0, 1);
        kick(10'd7, 10'd2, 4'd0, 10'd3, 1'b1, 16'h1111);
        wait_done("t4a");
        push_layer(10'd7, 10'd0, 4'd3, 10'd3, 1'b0, 16'h2222, 32'h0, 1);
        kick(10'd7, 10'd0, 4'd3, 10'd3, 1'b0, 16'h2222);
        wait_done("t4b");

        // 5: asynchronous reset during ACC, then a full rerun.
        push_layer(10'd5, 10'd3, 4'd2, 10'd40, 1'b1, 16'h00AB, 32'h7777_8888, 15);
        kick(10'd5, 10'd3, 4'd2, 10'd40, 1'b1, 16'h00AB);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        compares++;
        if (b_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got b_req=%b busy=%b done=%b want 0 0 0", b_req, busy, done);
        end
        cmd_q.delete(); dn_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        push_layer(10'd5, 10'd3, 4'd2, 10'd40, 1'b1, 16'h00AB, 32'h7777_8888, 15);
        kick(10'd5, 10'd3, 4'd2, 10'd40, 1'b1, 16'h00AB);
        wait_done("t5");

        // 6: norm8 skipped, activations captured from the read.
        push_layer(10'd100, 10'd2, 4'd1, 10'd9, 1'b0, 16'hBEEF, 32'hA5A5_0F0F, 9);
        kick(10'd100, 10'd2, 4'd1, 10'd9, 1'b0, 16'hBEEF);
        wait_done("t6");
        compares++;
        if (activ !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL activ_hold got=%h want=%h", activ, 32'hA5A5_0F0F);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
